// File: rtl/silife_max7219_rx.sv
// silife_max7219_rx: MAX7219-compatible SPI receiver with its own register file.
// Latency: a frame commits 1 cycle after CS rise is detected; register outputs follow 1 cycle later, and o_row_data 1 more.
// Backpressure: none. SPI is sampled free-running; SCK half-period and CS setup/hold must be >= 3 clk cycles.
// Ports: clk/reset (sync, active-high); spi_cs/spi_sck/spi_mosi async serial in, spi_dout daisy-chain out;
//        i_row_select/o_row_data digit readout; o_decode_mode..o_display_test register file;
//        o_frame_valid/o_frame_addr/o_frame_data/o_frame_err commit reporting.
module silife_max7219_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_cs,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_dout,
    input  logic [2:0] i_row_select,
    output logic [7:0] o_row_data,
    output logic [7:0] o_decode_mode,
    output logic [3:0] o_intensity,
    output logic [2:0] o_scan_limit,
    output logic       o_shutdown,
    output logic       o_display_test,
    output logic       o_frame_valid,
    output logic [3:0] o_frame_addr,
    output logic [7:0] o_frame_data,
    output logic       o_frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    // Synchronizers and delayed copies carry no reset: the delayed copy keeps
    // tracking the pins during reset, so a CS already low at release does not
    // look like a falling edge.
    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   cs_dly_q, sck_dly_q;

    always_ff @(posedge clk) begin
        cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
        sck_dly_q   <= sck_sync_q[SYNC_STAGES-1];
    end

    logic cs_s, sck_s, mosi_s;
    logic cs_fall, cs_rise, sck_rise, sck_fall;
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_dly_q & ~cs_s;
    assign cs_rise  = ~cs_dly_q & cs_s;
    assign sck_rise = ~sck_dly_q & sck_s;
    assign sck_fall = sck_dly_q & ~sck_s;

    state_t      state_q, state_d;
    logic [15:0] shift_q;
    logic [4:0]  cnt_q;
    logic        full_frame;
    assign full_frame = (cnt_q >= 5'd16);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = full_frame ? COMMIT : IDLE;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    logic clear_en, shift_en, dout_en, load_frame, commit_en, err_set;
    always_comb begin
        clear_en   = 1'b0;
        shift_en   = 1'b0;
        dout_en    = 1'b0;
        load_frame = 1'b0;
        commit_en  = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            IDLE:   clear_en = cs_fall;
            SHIFT: begin
                // A CS rise in the same cycle as an SCK rise wins; that bit is dropped.
                shift_en   = sck_rise & ~cs_rise;
                dout_en    = sck_fall;
                load_frame = cs_rise & full_frame;
                err_set    = cs_rise & ~full_frame;
            end
            COMMIT: commit_en = 1'b1;
            default: ;
        endcase
    end

    // Shift register, bit counter, daisy-chain output
    always_ff @(posedge clk) begin
        if (reset || clear_en) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shift_q <= {shift_q[14:0], mosi_s};
            if (cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
        end
        if (reset)        spi_dout <= 1'b0;
        else if (dout_en) spi_dout <= shift_q[15];
    end

    // Frame capture: the last 16 bits shifted are the frame
    logic       err_q;
    logic [2:0] digit_idx;
    assign digit_idx = o_frame_addr[2:0] - 3'd1;   // addr 8 wraps to index 7

    logic [7:0] digit_q [8];

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q          <= 1'b0;
            o_frame_addr   <= '0;
            o_frame_data   <= '0;
            o_decode_mode  <= '0;
            o_intensity    <= '0;
            o_scan_limit   <= '0;
            o_shutdown     <= 1'b1;
            o_display_test <= 1'b0;
            o_row_data     <= '0;
            for (int i = 0; i < 8; i++) digit_q[i] <= '0;
        end else begin
            err_q      <= err_set;
            o_row_data <= digit_q[i_row_select];
            if (load_frame) begin
                o_frame_addr <= shift_q[11:8];
                o_frame_data <= shift_q[7:0];
            end
            if (commit_en) begin
                if (o_frame_addr >= 4'h1 && o_frame_addr <= 4'h8)
                    digit_q[digit_idx] <= o_frame_data;
                case (o_frame_addr)
                    4'h9:    o_decode_mode  <= o_frame_data;
                    4'hA:    o_intensity    <= o_frame_data[3:0];
                    4'hB:    o_scan_limit   <= o_frame_data[2:0];
                    4'hC:    o_shutdown     <= ~o_frame_data[0];
                    4'hF:    o_display_test <= o_frame_data[0];
                    default: ;
                endcase
            end
        end
    end

    assign o_frame_valid = commit_en;
    assign o_frame_err   = err_q;

endmodule

// File: tb/tb_silife_max7219_rx.sv
// Bench for silife_max7219_rx: directed frames plus random frames against a
// register-file model built from the MAX7219 command rules.
module tb_silife_max7219_rx;
    localparam int H = 5;  // SCK half-period in clk cycles

    logic       clk = 0;
    logic       reset;
    logic       spi_cs, spi_sck, spi_mosi, spi_dout;
    logic [2:0] i_row_select;
    logic [7:0] o_row_data, o_decode_mode, o_frame_data;
    logic [3:0] o_intensity, o_frame_addr;
    logic [2:0] o_scan_limit;
    logic       o_shutdown, o_display_test, o_frame_valid, o_frame_err;

    silife_max7219_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_dout(spi_dout),
        .i_row_select(i_row_select), .o_row_data(o_row_data),
        .o_decode_mode(o_decode_mode), .o_intensity(o_intensity),
        .o_scan_limit(o_scan_limit), .o_shutdown(o_shutdown),
        .o_display_test(o_display_test), .o_frame_valid(o_frame_valid),
        .o_frame_addr(o_frame_addr), .o_frame_data(o_frame_data),
        .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor
    int         n_valid = 0, n_err = 0;
    logic [3:0] cap_addr;
    logic [7:0] cap_data;
    always @(negedge clk) begin
        if (o_frame_valid) begin
            n_valid++;
            cap_addr = o_frame_addr;
            cap_data = o_frame_data;
        end
        if (o_frame_err) n_err++;
    end

    // Reference model of the register file
    logic [7:0] m_dig [8];
    logic [7:0] m_decode, m_fdata;
    logic [3:0] m_int, m_faddr;
    logic [2:0] m_scan;
    logic       m_shut, m_test;

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
        m_decode = 0; m_int = 0; m_scan = 0; m_shut = 1; m_test = 0;
        m_faddr = 0; m_fdata = 0;
    endtask

    task automatic m_apply(input logic [15:0] w);
        int a;
        a = int'(w[11:8]);
        m_faddr = w[11:8];
        m_fdata = w[7:0];
        if (a >= 1 && a <= 8) m_dig[a-1] = w[7:0];
        else if (a == 9)  m_decode = w[7:0];
        else if (a == 10) m_int    = w[3:0];
        else if (a == 11) m_scan   = w[2:0];
        else if (a == 12) m_shut   = ~w[0];
        else if (a == 15) m_test   = w[0];
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic dout_samp [32];

    // Clock out nb bits MSB first; dout sampled just before each SCK rise
    task automatic clock_bits(input logic [31:0] w, input int nb, input bit coinc);
        for (int j = 0; j < nb; j++) begin
            spi_mosi = w[nb-1-j];
            wait_clks(H);
            dout_samp[j] = spi_dout;
            spi_sck = 1;
            if (coinc && j == nb-1) spi_cs = 1;
            wait_clks(H);
            spi_sck = 0;
        end
    endtask

    task automatic send(input logic [31:0] w, input int nb, input bit coinc);
        spi_cs = 0;
        wait_clks(H);
        clock_bits(w, nb, coinc);
        if (!coinc) begin
            wait_clks(H);
            spi_cs = 1;
        end
        wait_clks(H + 4);
    endtask

    task automatic frame(input string tag, input logic [31:0] w, input int nb, input bit coinc);
        int v0, e0, eff;
        v0 = n_valid; e0 = n_err;
        eff = coinc ? nb - 1 : nb;
        send(w, nb, coinc);
        if (eff >= 16) begin
            m_apply(w[15:0] >> (nb - eff));
            check({tag, "_valid"}, n_valid - v0, 1);
            check({tag, "_err"},   n_err - e0,   0);
            check({tag, "_caddr"}, cap_addr, m_faddr);
            check({tag, "_cdata"}, cap_data, m_fdata);
        end else begin
            check({tag, "_valid"}, n_valid - v0, 0);
            check({tag, "_err"},   n_err - e0,   1);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < 8; r++) begin
            i_row_select = 3'(r);
            wait_clks(1);  // one-cycle readout latency
            check($sformatf("%s_row%0d", tag, r), o_row_data, m_dig[r]);
        end
        check({tag, "_decode"}, o_decode_mode,  m_decode);
        check({tag, "_int"},    o_intensity,    m_int);
        check({tag, "_scan"},   o_scan_limit,   m_scan);
        check({tag, "_shut"},   o_shutdown,     m_shut);
        check({tag, "_test"},   o_display_test, m_test);
        check({tag, "_faddr"},  o_frame_addr,   m_faddr);
        check({tag, "_fdata"},  o_frame_data,   m_fdata);
    endtask

    initial begin
        logic [15:0] dw;
        int v0, e0;
        reset = 1; spi_cs = 1; spi_sck = 0; spi_mosi = 0; i_row_select = 0;
        m_reset();
        wait_clks(6);
        check("rst_dout", spi_dout, 0);
        check("rst_valid", o_frame_valid, 0);
        check("rst_err", o_frame_err, 0);
        reset = 0;
        wait_clks(4);
        check_regs("rst");

        // Digit write and readout
        frame("f0355", 32'h0355, 16, 0);
        i_row_select = 3'd2;
        wait_clks(1);
        check("row2_after", o_row_data, 8'h55);
        check_regs("f0355");

        // Control registers
        frame("f0C01", 32'h0C01, 16, 0);
        frame("f0A07", 32'h0A07, 16, 0);
        frame("f0B05", 32'h0B05, 16, 0);
        check("shut0", o_shutdown, 0);
        check("int7", o_intensity, 7);
        check("scan5", o_scan_limit, 5);
        check_regs("ctrl");

        // 32-bit daisy-chained frame: only the last 16 bits commit
        frame("f32", 32'h0111_0822, 32, 0);
        check("dig7", m_dig[7], 8'h22);
        check_regs("f32");
        dw = '0;
        for (int j = 16; j < 32; j++) dw[31-j] = dout_samp[j];
        check("dout_chain", dw, 16'h0111);
        check("dout_pre", dout_samp[15], 0);

        // Short frames
        frame("short10", 32'h2AB, 10, 0);
        frame("glitch0", 32'h0, 0, 0);
        check_regs("short");

        // Reset in the middle of a frame, released with CS still low
        v0 = n_valid; e0 = n_err;
        spi_cs = 0;
        wait_clks(H);
        clock_bits(32'h01, 8, 0);
        reset = 1;
        wait_clks(4);
        reset = 0;
        m_reset();
        clock_bits(32'hFF, 8, 0);
        wait_clks(H);
        spi_cs = 1;
        wait_clks(H + 4);
        check("midrst_valid", n_valid - v0, 0);
        check("midrst_err", n_err - e0, 0);
        check_regs("midrst");

        // CS rise coincident with the 16th SCK rise drops that bit
        frame("coinc", 32'h0F01, 16, 1);
        check_regs("coinc");
        frame("f0F01", 32'h0F01, 16, 0);
        check("dtest1", o_display_test, 1);

        // Random frames: full, daisy-chained, short and coincident
        for (int it = 0; it < 30; it++) begin
            int k, nb;
            bit co;
            k = $urandom_range(0, 9);
            co = 0;
            if (k == 0)      nb = $urandom_range(0, 15);
            else if (k == 1) nb = $urandom_range(17, 31);
            else if (k == 2) begin nb = $urandom_range(16, 18); co = 1; end
            else             nb = 16;
            frame($sformatf("rnd%0d", it), $urandom, nb, co);
            check_regs($sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/silife_max7219_rx.md
Name: silife_max7219_rx

Overview:
- SPI receiver for the MAX7219 serial protocol. It is the far end of the display link that the life-engine driver transmits on.
- Oversamples CS/SCK/MOSI in the system clock domain, assembles 16-bit command frames and commits them on the CS rising edge.
- Maintains a MAX7219-equivalent register file: 8 digit rows, decode mode, intensity, scan limit, shutdown and display test.
- Used for on-chip loopback of the display path and as a checker model in system benches.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer for spi_cs, spi_sck and spi_mosi (minimum 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- spi_cs  in  1  LOAD/CS, active low; asynchronous to clk
- spi_sck  in  1  serial clock; asynchronous to clk
- spi_mosi  in  1  serial data, MSB first; asynchronous to clk
- spi_dout  out  1  daisy-chain output: the MSB of the shift register, updated on SCK falling
- i_row_select  in  3  digit row to read out
- o_row_data  out  8  digit register addressed by i_row_select; registered, 1-cycle latency
- o_decode_mode  out  8  register 0x9
- o_intensity  out  4  register 0xA, bits [3:0]
- o_scan_limit  out  3  register 0xB, bits [2:0]
- o_shutdown  out  1  1 = shutdown; written as the inverse of register 0xC bit 0
- o_display_test  out  1  register 0xF, bit 0
- o_frame_valid  out  1  1-cycle pulse when a frame is committed
- o_frame_addr  out  4  address nibble of the last committed frame
- o_frame_data  out  8  data byte of the last committed frame
- o_frame_err  out  1  1-cycle pulse when CS rises after fewer than 16 bits

Behaviour:
- Inputs pass through SYNC_STAGES flip-flops. Edges are detected on the synchronized signals by comparing against a 1-cycle-delayed copy.
- Supported SCK half-period is at least 3 clk cycles. CS setup and hold are at least 3 clk cycles.
- State machine:
  - IDLE -> SHIFT on CS falling. Entering SHIFT clears the shift register (16 bits) and the bit counter (5 bits, saturating at 31).
  - SHIFT, SCK rising: shift_reg <= {shift_reg[14:0], mosi_sync}; the counter increments and saturates at 31.
  - SHIFT, SCK falling: spi_dout <= shift_reg[15].
  - SHIFT -> COMMIT on CS rising when the counter is at least 16; the last 16 bits received are used (daisy-chain semantics).
  - SHIFT -> IDLE on CS rising when the counter is below 16; o_frame_err pulses and no register changes.
  - COMMIT lasts 1 cycle, then returns to IDLE.
- COMMIT decodes addr = shift_reg[11:8] and data = shift_reg[7:0]; shift_reg[15:12] is ignored.
  - Address 0x0 is a no-op.
  - Addresses 0x1-0x8 write digit[addr-1] <= data.
  - 0x9 writes decode mode; 0xA writes intensity <= data[3:0]; 0xB writes scan limit <= data[2:0].
  - 0xC writes shutdown <= ~data[0]; 0xF writes display test <= data[0].
  - 0xD and 0xE are ignored.
- o_frame_valid pulses in the COMMIT cycle for every address, including no-op and ignored addresses. o_frame_addr and o_frame_data update in that same cycle and hold until the next commit.
- Register outputs reflect a write on the cycle after COMMIT.
- SCK edges seen in IDLE (CS high) are ignored.
- If CS rising and SCK rising are detected in the same cycle, CS wins and that SCK edge is discarded.
- CS falling while already in SHIFT cannot occur, because a rising edge must come first.
- A glitch frame of 0 bits (CS low then high with no SCK) produces o_frame_err.
- Reset values:
  - digits: 0
  - decode mode, intensity, scan limit, display test: 0
  - shutdown: 1
  - spi_dout, o_frame_*, o_row_data: 0
  - state: IDLE
- Reset mid-frame discards the partial frame. After reset the FSM waits for a fresh CS falling edge; a CS that is already low is not treated as a frame start.
- o_row_data <= digit[i_row_select] every cycle.

Test Plan:
- Frame 0x0355 (16 SCKs, MSB first) -> o_frame_valid for 1 cycle with addr 3, data 0x55. With i_row_select=2, o_row_data=0x55 one cycle later.
- Frames 0x0C01 then 0x0A07 then 0x0B05 -> o_shutdown=0, o_intensity=7, o_scan_limit=5. Other registers unchanged.
- Frame of 32 bits, 0x0111 followed by 0x0822 -> only digit7=0x22 is written and digit0 stays 0. spi_dout reproduces the first 16 bits (0x0111), delayed by 16 SCK cycles.
- CS low, 10 SCKs, CS high -> o_frame_err pulses once, no o_frame_valid, all registers unchanged.
- Reset asserted after 8 bits of 0x01FF, then released with CS still low, 8 more SCKs, CS high -> no commit and no error. All registers are at reset values with o_shutdown=1.
- CS rising coincident with the 16th SCK rising edge -> the 16th bit is dropped and o_frame_err pulses. Frame 0x0F01 with normal timing -> o_display_test=1.
